// File: rtl/uart_rx_fifo_writer.sv
// uart_rx_fifo_writer: recovers 8N1 (optionally 8E1) UART frames from rx and
//   pushes each good byte into an RX FIFO through a single-cycle write strobe.
// Ports: clk/rst_n (sync, active low); rx (async serial in); full_fifo (FIFO full);
//   we_fifo/data_fifo (FIFO write port); busy_rx; frame_err/overrun/parity_err pulses.
// Latency: we_fifo is asserted in the cycle after the mid-stop-bit sample.
// Backpressure: none upstream; a byte arriving while full_fifo=1 is dropped with overrun.
// Optional macro PARITY_EN: adds an even-parity bit after the data bits.
module uart_rx_fifo_writer #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 full_fifo,
  output logic                 we_fifo,
  output logic [DATA_BITS-1:0] data_fifo,
  output logic                 busy_rx,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;
`endif

  state_t               state, state_nx;
  logic [CW-1:0]        clk_cnt, clk_nx;
  logic [BW-1:0]        bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic [DATA_BITS-1:0] hold;
  logic                 rx_meta, rx_s, rx_d;
  logic                 fall;
  logic                 fe_nx, fe_q;
  logic                 pe_nx, pe_q;
  logic                 par_bad, par_bad_nx;

  // Synchroniser and edge-detect flops reset to the idle-high line level so
  // that leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Only a genuine high-to-low transition starts a frame; a held-low line
  // (break) cannot retrigger.
  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      hold    <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_nx;
      clk_cnt <= clk_nx;
      bit_cnt <= bit_nx;
      shift   <= shift_nx;
      fe_q    <= fe_nx;
      pe_q    <= pe_nx;
      par_bad <= par_bad_nx;
      if (we_fifo) hold <= shift;
    end
  end

  always_comb begin
    state_nx   = state;
    clk_nx     = clk_cnt;
    bit_nx     = bit_cnt;
    shift_nx   = shift;
    fe_nx      = 1'b0;
    pe_nx      = 1'b0;
    par_bad_nx = par_bad;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nx   = START;
          clk_nx     = '0;
          bit_nx     = '0;
          par_bad_nx = 1'b0;
        end
      end
      START: begin
        // Mid start bit: a line that is already high again was a glitch.
        if (clk_cnt == HALF_M1) begin
          clk_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end else begin
          clk_nx = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_nx   = '0;
          // Shift in at the MSB so the first (LSB) bit ends at bit 0.
          shift_nx = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_nx = '0;
`ifdef PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_nx = bit_cnt + BW'(1);
          end
        end else begin
          clk_nx = clk_cnt + CW'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_M1) begin
          clk_nx     = '0;
          par_bad_nx = ^{shift, rx_s};
          pe_nx      = ^{shift, rx_s};
          state_nx   = STOP;
        end else begin
          clk_nx = clk_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop keeps half a bit of margin for a back-to-back start edge.
        if (clk_cnt == FULL_M1) begin
          clk_nx = '0;
          if (!rx_s) begin
            fe_nx    = 1'b1;
            state_nx = IDLE;
          end else if (par_bad) begin
            state_nx = IDLE;
          end else begin
            state_nx = WRITE;
          end
        end else begin
          clk_nx = clk_cnt + CW'(1);
        end
      end
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy_rx   = (state != IDLE);
  assign we_fifo   = (state == WRITE) & ~full_fifo;
  assign overrun   = (state == WRITE) & full_fifo;
  // The fresh byte is presented combinationally in the write cycle; otherwise
  // the last written byte is held.
  assign data_fifo = we_fifo ? shift : hold;
  assign frame_err = fe_q;
`ifdef PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
